// File: rtl/decoder_scan_ctrl.sv
// Scan controller that drives the A/B select and active-low enable of a 2-to-4 decoder.
// Each code is held for DWELL cycles, followed by BLANK cycles with the decoder disabled.
module decoder_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int BLANK = 1,
  parameter int CNT_W = 8
) (
  input  logic clock,
  input  logic reset_b,
  input  logic start,
  input  logic mode,
  input  logic stop,
  output logic A,
  output logic B,
  output logic enable,
  output logic busy,
  output logic sweep_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam bit              HAS_GAP    = (BLANK > 0);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               end_of_code;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      sel_q    <= 2'b00;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      enable_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    done_d      = 1'b0;
    end_of_code = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = DRIVE;
          sel_d   = 2'b00;
          cnt_d   = '0;
          mode_d  = mode;
        end
      end
      DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (HAS_GAP) begin
            state_d = GAP;
          end else begin
            end_of_code = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d       = '0;
          end_of_code = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'b00;
        cnt_d   = '0;
      end
    endcase

    // Code 11 wraps to 00 only here; single-sweep mode returns to IDLE instead.
    if (end_of_code) begin
      if (sel_q != 2'b11) begin
        sel_d   = sel_q + 2'd1;
        state_d = DRIVE;
      end else begin
        sel_d   = 2'b00;
        done_d  = 1'b1;
        state_d = mode_q ? IDLE : DRIVE;
      end
    end

    // Stop overrides everything, including a sweep completion on the same edge.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      sel_d   = 2'b00;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    enable_d = (state_d != DRIVE);
    busy_d   = (state_d != IDLE);
  end

  assign A          = sel_q[1];
  assign B          = sel_q[0];
  assign enable     = enable_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequential scan controller that sits directly upstream of the two-to-four-line decoder with active-low enable and active-low outputs. It steps the decoder's select inputs A,B through 00→01→10→11 and holds each code for a programmable dwell time. Between codes it can insert blanking cycles with the decoder disabled, which prevents ghosting on the driven lines. It supports single-sweep and continuous modes with start/stop control, and flags each completed sweep, so a downstream display or row-scan stage needs no timing logic of its own.

## Interface
- DWELL, 4: cycles each select code is driven with enable low; legal range ≥1.
- BLANK, 1: cycles of enable high between consecutive codes; legal range ≥0 (0 = no blanking).
- CNT_W, 8: dwell/blank counter width; must hold max(DWELL,BLANK)-1.
- clock  input  1  rising-edge clock; only clock.
- reset_b  input  1  asynchronous, active-low reset.
- start  input  1  begin scanning; sampled at rising edge, honoured only in IDLE.
- mode  input  1  0 = continuous, 1 = single sweep; latched when start is accepted.
- stop  input  1  abort request; sampled at rising edge; priority over start.
- A  output  1  select MSB to decoder (registered).
- B  output  1  select LSB to decoder (registered).
- enable  output  1  active-low decoder enable (registered); 1 = all decoder outputs high.
- busy  output  1  high in DRIVE or GAP.
- sweep_done  output  1  one-cycle pulse when code 11 finishes its dwell and blanking.

## Operation
- Reset (reset_b=0, asynchronous): state IDLE, sel=00 (A=0,B=0), enable=1, busy=0, sweep_done=0, counter=0, latched mode=0.
- States are IDLE, DRIVE and GAP. {A,B} always equals the internal sel. enable=0 only in DRIVE.
- IDLE: on start=1 and stop=0:
  - next state DRIVE, sel=00, counter=0, mode latched, busy=1.
- DRIVE: the counter increments every cycle. When counter==DWELL-1:
  - counter is cleared;
  - next state is GAP if BLANK>0;
  - otherwise the end-of-code action runs immediately.
- GAP: enable=1 and sel is held; the counter increments. When counter==BLANK-1, the counter is cleared and the end-of-code action runs.
- End-of-code action:
  - sel≠11: sel=sel+1, next state DRIVE.
  - sel==11 and latched mode=1: next state IDLE, sel=00, sweep_done pulses.
  - sel==11 and latched mode=0: sel=00, next state DRIVE, sweep_done pulses.
- stop=1 in DRIVE or GAP: next state IDLE, sel=00, enable=1, counter=0, no sweep_done pulse. stop=1 in IDLE does nothing.
- If stop and an end-of-code event fall on the same edge, stop wins and no sweep_done is generated.
- start while busy is ignored. mode changes while busy are ignored.
- sel arithmetic is 2-bit; the wrap from 11 to 00 occurs only through the end-of-code action.

## Timing
- All outputs are registered and change only on the rising edge of clock or on reset_b falling.
- Start latency: start=1 sampled at edge k gives enable=0 and {A,B}=00 from edge k until edge k+DWELL.
- Each code lasts DWELL+BLANK cycles.
- One sweep lasts 4·(DWELL+BLANK) cycles from the first enable=0 to the sweep_done cycle.
- sweep_done is high for exactly the one cycle following the last cycle of code 11. In single mode, busy=0 in that same cycle.
- With BLANK=0, enable stays low across code changes and {A,B} changes on the same edge that ends the dwell.
- Stop latency: stop sampled at edge k gives enable=1, busy=0 and {A,B}=00 after edge k.
- Reset mid-scan takes effect immediately without a clock. Scanning resumes only on a new start after reset_b=1.
- Back-to-back sweeps: start may be accepted in the sweep_done cycle of a single sweep, i.e. the first IDLE cycle.

## Test plan
- Reset/idle: hold reset_b=0, then release with start=0 for 10 cycles → A=0, B=0, enable=1, busy=0, sweep_done=0 throughout.
- Single sweep, DWELL=4, BLANK=1: pulse start with mode=1 at edge 0.
  - enable=0 with AB=00 for cycles 0–3, enable=1 in cycle 4; the same pattern repeats for 01, 10 and 11.
  - sweep_done=1 and busy=0 in cycle 20 only.
- Continuous, DWELL=2, BLANK=0: start with mode=0 → AB sequence 00,00,01,01,10,10,11,11,00…; enable stays 0; sweep_done pulses every 8 cycles.
- Stop mid-scan: continuous run, assert stop while AB=10 in DRIVE → next cycle enable=1, AB=00, busy=0, no sweep_done; a start asserted during the run is ignored.
- Stop versus wrap: assert stop on the edge that ends code 11 in continuous mode → IDLE, sweep_done stays 0.
- Async reset: drop reset_b mid-clock while AB=01 in DRIVE → enable=1 and AB=00 before the next edge; no activity until a new start.
